// File: rtl/oet_sorter_pkg.sv
// Shared FSM encodings and default sizes for the sorter family.
// SORTER_DESC_EN (define) flips the sort direction to descending.
package oet_sorter_pkg;

  localparam int SORTER_DATA_W = 8;
  localparam int SORTER_DEPTH  = 8;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SORT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/oet_sorter_cmp_swap.sv
// Combinational compare-exchange for one element pair.
// SORTER_DESC_EN selects descending order; default is ascending.
module cmp_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic sel;

  // lo lands at the lower buffer index; equal values never swap
`ifdef SORTER_DESC_EN
  assign sel = a < b;
`else
  assign sel = a > b;
`endif

  assign lo = sel ? b : a;
  assign hi = sel ? a : b;

endmodule

// File: rtl/oet_sorter.sv
// Frame sorter: load DEPTH words, odd-even transposition sort, drain.
// SORTER_DESC_EN (define) sorts descending; timing is unchanged.
module oet_sorter
  import oet_sorter_pkg::*;
#(
  parameter int DATA_W = SORTER_DATA_W,
  parameter int DEPTH  = SORTER_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int NP = DEPTH / 2;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [1:0]        state;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     phase;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] nxt [DEPTH];
  logic [DATA_W-1:0] ca  [NP];
  logic [DATA_W-1:0] cb  [NP];
  logic [DATA_W-1:0] clo [NP];
  logic [DATA_W-1:0] chi [NP];

  logic ld;
  logic st;
  logic dr;
  logic in_fire;
  logic out_fire;

  assign ld = state == ST_LOAD;
  assign st = state == ST_SORT;
  assign dr = state == ST_DRAIN;

  // all outputs forced low while reset is held
  assign in_ready  = rst_n & ld;
  assign busy      = rst_n & (st | dr);
  assign out_valid = rst_n & dr;
  assign out_last  = out_valid & (rd_idx == LAST);
  assign out_data  = out_valid ? out_q : '0;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  for (genvar k = 0; k < NP; k++) begin : g_cs
    if (k < NP - 1) begin : g_mid
      assign ca[k] = phase[0] ? mem[2*k+1] : mem[2*k];
      assign cb[k] = phase[0] ? mem[2*k+2] : mem[2*k+1];
    end else begin : g_end
      // top pair has no odd-phase partner
      assign ca[k] = mem[2*k];
      assign cb[k] = mem[2*k+1];
    end

    cmp_swap #(
      .DATA_W(DATA_W)
    ) u_cs (
      .a (ca[k]),
      .b (cb[k]),
      .lo(clo[k]),
      .hi(chi[k])
    );
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = mem[i];
    end
    if (!phase[0]) begin
      for (int k = 0; k < NP; k++) begin
        nxt[2*k]   = clo[k];
        nxt[2*k+1] = chi[k];
      end
    end else begin
      for (int k = 0; k < NP - 1; k++) begin
        nxt[2*k+1] = clo[k];
        nxt[2*k+2] = chi[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_idx] <= in_data;
    end else if (st) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      phase  <= '0;
      out_q  <= '0;
    end else begin
      unique case (1'b1)
        ld: begin
          if (in_fire) begin
            if (wr_idx == LAST) begin
              wr_idx <= '0;
              state  <= ST_SORT;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        st: begin
          if (phase == LAST) begin
            phase <= '0;
            state <= ST_DRAIN;
            // prefetch from the final phase result
            out_q <= nxt[0];
          end else begin
            phase <= phase + 1'b1;
          end
        end
        dr: begin
          if (out_fire) begin
            if (rd_idx == LAST) begin
              rd_idx <= '0;
              state  <= ST_LOAD;
            end else begin
              rd_idx <= rd_idx + 1'b1;
              out_q  <= mem[rd_idx + 1'b1];
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_oet_sorter.sv
// Scoreboard bench for oet_sorter; expected order follows
// SORTER_DESC_EN when the bench is built with it.
module tb_oet_sorter;
  import oet_sorter_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  oet_sorter #(
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ocnt = 0;
  int otot = 0;
  int t_last = 0;
  int t_olast = 0;
  int rdy_mode = 0;
  bit lat_pend = 0;
  bit mon_en = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push_exp(input logic [DW-1:0] f [DEPTH]);
    logic [DW-1:0] s [DEPTH];
    logic [DW-1:0] t;
    bit sw;
    s = f;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH - 1 - i; j++) begin
`ifdef SORTER_DESC_EN
        sw = s[j] < s[j+1];
`else
        sw = s[j] > s[j+1];
`endif
        if (sw) begin
          t = s[j];
          s[j] = s[j+1];
          s[j+1] = t;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(s[i]);
  endtask

  // entered and left at posedge+1
  task automatic send_frame(input logic [DW-1:0] f [DEPTH],
                            input bit gaps,
                            output int t_first);
    int n;
    t_first = 0;
    push_exp(f);
    for (int i = 0; i < DEPTH; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(posedge clk);
          #1;
        end
      end
      in_data  = f[i];
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        check("in_timeout", in_ready, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      if (i == 0) t_first = cyc;
      if (i == DEPTH - 1) begin
        t_last = cyc;
        lat_pend = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (busy) check("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        if (lat_pend) begin
          check("latency", cyc - t_last, DEPTH);
          lat_pend = 1'b0;
        end
        if (prev_stall) check("stable", out_data, prev_data);
        check("out_last", out_last, ocnt == DEPTH - 1);
        if (out_ready) begin
          check("exp_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
          if (ocnt == DEPTH - 1) begin
            ocnt = 0;
            t_olast = cyc + 1;
          end else begin
            ocnt++;
          end
          otot++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] f [DEPTH];
    int tf;
    int n;
    int base;

    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;

    f = '{7, 6, 5, 4, 3, 2, 1, 0};
    send_frame(f, 0, tf);
    wait_drain();

    f = '{3, 1, 3, 0, 255, 1, 0, 255};
    send_frame(f, 0, tf);
    wait_drain();

    rdy_mode = 1;
    for (int i = 0; i < DEPTH; i++) f[i] = DW'($urandom_range(0, 255));
    send_frame(f, 1, tf);
    wait_drain();
    rdy_mode = 2;
    for (int i = 0; i < DEPTH; i++) f[i] = DW'($urandom_range(0, 15));
    send_frame(f, 1, tf);
    wait_drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    base = otot;
    f = '{9, 200, 4, 77, 4, 31, 150, 2};
    send_frame(f, 0, tf);
    n = 0;
    while (otot < base + 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("rst_drain_reached", otot >= base + 3, 1);
    rst_n = 1'b0;
    exp_q.delete();
    ocnt = 0;
    lat_pend = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    f = '{80, 70, 60, 50, 40, 30, 20, 10};
    send_frame(f, 0, tf);
    wait_drain();

    f = '{5, 9, 1, 200, 200, 0, 33, 7};
    send_frame(f, 0, tf);
    f = '{100, 3, 3, 250, 64, 8, 129, 1};
    send_frame(f, 0, tf);
    check("b2b_first", tf, t_olast + 1);
    wait_drain();

    f = '{0, 1, 2, 3, 4, 5, 6, 7};
    send_frame(f, 0, tf);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
